wide_add_sequencer: RTL and testbench

Multi-precision add sequencer that computes an N·K-bit sum using a single shared N-bit ripple-carry adder (`N_bit_adder`). It processes one N-bit limb per clock, least-significant limb first, and chains the carry through a register. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It lets wide arithmetic reuse the existing narrow adder instead of instantiating an N·K-bit carry chain.

---
 rtl/wide_add_sequencer_pkg.sv | 12 +
 rtl/wide_add_sequencer_if.sv | 39 +++
 rtl/wide_add_sequencer_N_bit_adder.sv | 23 ++
 rtl/wide_add_sequencer.sv | 91 +++++++++
 tb/tb_wide_add_sequencer.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/wide_add_sequencer_pkg.sv
// Shared types and helpers for the limb-serial wide adder.
package add_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

  function automatic int unsigned idx_w(input int unsigned k);
    int unsigned w;
    w = $clog2(k);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/wide_add_sequencer_if.sv
// Operand/result handshake bundle for wide_add_sequencer.
// The ovf signal exists only when ADD_SEQ_OVF_EN is defined.
interface wide_add_sequencer_if #(
  parameter int unsigned N = 8,
  parameter int unsigned K = 4
);
  localparam int unsigned W = N * K;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum_out;
  logic         c_out;
  logic         busy;
`ifdef ADD_SEQ_OVF_EN
  logic         ovf;
`endif

  modport master (
    output in_valid, a_in, b_in, c_in, out_ready,
    input  in_ready, out_valid, sum_out, c_out, busy
`ifdef ADD_SEQ_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a_in, b_in, c_in, out_ready,
    output in_ready, out_valid, sum_out, c_out, busy
`ifdef ADD_SEQ_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/wide_add_sequencer_N_bit_adder.sv
// Combinational N-bit ripple-carry adder, shared by every limb of the sequencer.
module N_bit_adder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  always_comb begin
    logic c;
    sum_o = '0;
    c     = cin_i;
    for (int unsigned i = 0; i < N; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// N*K-bit adder that reuses one N-bit adder, one limb per clock, LS limb first.
// Optional signed-overflow flag enabled by defining ADD_SEQ_OVF_EN.
module wide_add_sequencer
  import add_seq_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned K = 4
) (
  input logic                clk,
  input logic                rst,
  wide_add_sequencer_if.slave bus
);

  localparam int unsigned    W    = N * K;
  localparam int unsigned    IW   = idx_w(K);
  localparam logic [IW-1:0]  LAST = IW'(K - 1);

  seq_state_t    state_q;
  logic [W-1:0]  a_q, b_q, sum_q;
  logic          carry_q;
  logic [IW-1:0] idx_q;
`ifdef ADD_SEQ_OVF_EN
  logic          ovf_q;
`endif

  logic [N-1:0]  limb_a, limb_b, limb_s;
  logic          limb_c;

  assign limb_a = a_q[idx_q*N +: N];
  assign limb_b = b_q[idx_q*N +: N];

  N_bit_adder #(.N(N)) u_adder (
    .a_i    (limb_a),
    .b_i    (limb_b),
    .cin_i  (carry_q),
    .sum_o  (limb_s),
    .cout_o (limb_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
`ifdef ADD_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a_in;
            b_q     <= bus.b_in;
            carry_q <= bus.c_in;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[idx_q*N +: N] <= limb_s;
          carry_q             <= limb_c;
          // Index wraps to 0 on the last limb so it never points past the operand.
          idx_q               <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
          if (idx_q == LAST) begin
            state_q <= DONE;
`ifdef ADD_SEQ_OVF_EN
            ovf_q   <= (a_q[W-1] == b_q[W-1]) && (limb_s[N-1] != a_q[W-1]);
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == RUN);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum_out   = sum_q;
  assign bus.c_out     = carry_q;
`ifdef ADD_SEQ_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer: N=8/K=4 scenarios plus a K=1 instance with a sweep.
module tb_wide_add_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  wide_add_sequencer_if #(.N(8), .K(4)) ifc4 ();
  wide_add_sequencer_if #(.N(8), .K(1)) ifc1 ();

  wide_add_sequencer #(.N(8), .K(4)) dut4 (.clk(clk), .rst(rst), .bus(ifc4));
  wide_add_sequencer #(.N(8), .K(1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One K=4 transaction; garbage on the input side during RUN must not leak in.
  task automatic run4(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic c, input logic [31:0] es, input logic ec,
                      input logic eovf, input int hold);
    int lat;
    int bcnt;
    logic [31:0] held;
    chk({tag, "_in_ready"}, 64'(ifc4.in_ready), 64'd1);
    ifc4.a_in = a; ifc4.b_in = b; ifc4.c_in = c; ifc4.in_valid = 1'b1;
    ifc4.out_ready = 1'b0;
    step();
    ifc4.a_in = ~a; ifc4.b_in = ~b; ifc4.c_in = ~c;
    lat = 0; bcnt = 0;
    while (!ifc4.out_valid && lat < 20) begin
      if (ifc4.busy) bcnt++;
      step();
      lat++;
    end
    ifc4.in_valid = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'd4);
    chk({tag, "_busy_cycles"}, 64'(bcnt), 64'd4);
    chk({tag, "_busy_done"}, 64'(ifc4.busy), 64'd0);
    chk({tag, "_sum"}, 64'(ifc4.sum_out), 64'(es));
    chk({tag, "_cout"}, 64'(ifc4.c_out), 64'(ec));
`ifdef ADD_SEQ_OVF_EN
    chk({tag, "_ovf"}, 64'(ifc4.ovf), 64'(eovf));
`else
    if (eovf === 1'bx) $display("note: ovf expectation unused");
`endif
    held = ifc4.sum_out;
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_valid"}, 64'(ifc4.out_valid), 64'd1);
      chk({tag, "_hold_sum"}, 64'(ifc4.sum_out), 64'(held));
      chk({tag, "_hold_in_ready"}, 64'(ifc4.in_ready), 64'd0);
    end
    ifc4.out_ready = 1'b1;
    step();
    ifc4.out_ready = 1'b0;
    chk({tag, "_after_valid"}, 64'(ifc4.out_valid), 64'd0);
    chk({tag, "_after_in_ready"}, 64'(ifc4.in_ready), 64'd1);
  endtask

  task automatic run1(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c);
    int lat;
    logic [8:0] ref_v;
    logic eovf;
    ref_v = {1'b0, a} + {1'b0, b} + {8'd0, c};
    eovf  = (a[7] == b[7]) && (ref_v[7] != a[7]);
    ifc1.a_in = a; ifc1.b_in = b; ifc1.c_in = c; ifc1.in_valid = 1'b1;
    ifc1.out_ready = 1'b0;
    step();
    ifc1.in_valid = 1'b0;
    lat = 0;
    while (!ifc1.out_valid && lat < 10) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd1);
    chk({tag, "_result"}, 64'({ifc1.c_out, ifc1.sum_out}), 64'(ref_v));
`ifdef ADD_SEQ_OVF_EN
    chk({tag, "_ovf"}, 64'(ifc1.ovf), 64'(eovf));
`else
    if (eovf === 1'bx) $display("note: ovf expectation unused");
`endif
    ifc1.out_ready = 1'b1;
    step();
    ifc1.out_ready = 1'b0;
  endtask

  initial begin
    ifc4.in_valid = 1'b0; ifc4.a_in = '0; ifc4.b_in = '0; ifc4.c_in = 1'b0; ifc4.out_ready = 1'b0;
    ifc1.in_valid = 1'b0; ifc1.a_in = '0; ifc1.b_in = '0; ifc1.c_in = 1'b0; ifc1.out_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    chk("rst_in_ready", 64'(ifc4.in_ready), 64'd1);
    chk("rst_out_valid", 64'(ifc4.out_valid), 64'd0);
    chk("rst_busy", 64'(ifc4.busy), 64'd0);
    chk("rst_sum", 64'(ifc4.sum_out), 64'd0);
    chk("rst_cout", 64'(ifc4.c_out), 64'd0);
`ifdef ADD_SEQ_OVF_EN
    chk("rst_ovf", 64'(ifc4.ovf), 64'd0);
`endif

    run4("t1_ff_plus_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 0);
    run4("t2_carry_wrap", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 0);
    run4("t3_pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0);
    run4("t3_mixed", 32'h0000_001E, 32'hFFFF_FFF6, 1'b0, 32'h0000_0014, 1'b1, 1'b0, 0);
    run4("t4_backpressure", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 3);
    run4("t4_next_accept", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 0);

    // Reset during the second RUN cycle discards the in-flight result.
    ifc4.a_in = 32'h1111_1111; ifc4.b_in = 32'h2222_2222; ifc4.c_in = 1'b1; ifc4.in_valid = 1'b1;
    step();
    ifc4.in_valid = 1'b0;
    step();
    chk("t5_in_run", 64'(ifc4.busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_valid", 64'(ifc4.out_valid), 64'd0);
    chk("t5_rst_busy", 64'(ifc4.busy), 64'd0);
    chk("t5_rst_in_ready", 64'(ifc4.in_ready), 64'd1);
    chk("t5_rst_sum", 64'(ifc4.sum_out), 64'd0);
    chk("t5_rst_cout", 64'(ifc4.c_out), 64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_no_stale_valid", 64'(ifc4.out_valid), 64'd0);
    end
    run4("t5_5_plus_3", 32'd5, 32'd3, 1'b0, 32'd8, 1'b0, 1'b0, 0);

    run1("t6_k1_127_plus_1", 8'd127, 8'd1, 1'b0);
    chk("t6_k1_sum_0x80", 64'(ifc1.sum_out), 64'h80);
    run1("t6_k1_wrap", 8'hFF, 8'h00, 1'b1);
    for (int i = 0; i < 200; i++) begin
      run1("t6_sweep", 8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
